mux_scan_sequencer: RTL and testbench

Sequential front end for the 16:1 multiplexer. It drives the mux `sel` lines through the enabled channels in ascending order and captures each selected 4-bit word. Each captured word is presented downstream on a valid/ready handshake, tagged with its channel number. The block sits between the bank of 16 channel registers / mux (which it steers and reads) and any serial consumer (UART framer, FIFO, display driver).

---
 rtl/mux_scan_sequencer_pkg.sv | 17 +
 rtl/mux_scan_sequencer_next_chan_find.sv | 46 ++++
 rtl/mux_scan_sequencer.sv | 136 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// scan_pkg: shared types and constants for the mux scan sequencer.
//   state_t : scan FSM states (IDLE, SEL, OUT, DONE)
//   NCH     : number of mux channels
//   SEL_W   : mux select width
package scan_pkg;

  localparam int NCH   = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_sequencer_next_chan_find.sv
// next_chan_find: combinational search for the next enabled channel.
// Ports:
//   mask  in  2**SEL_W  channel enable mask
//   idx   in  SEL_W     current channel index
//   incl  in  1         1: idx itself is a candidate (start search from idx)
//                       0: only channels strictly above idx are candidates
//   wrap  in  1         if nothing qualifies, fall back to lowest set bit of mask
//   nxt   out SEL_W     lowest qualifying channel
//   found out 1         a qualifying channel exists
module next_chan_find #(
  parameter int SEL_W = 4
) (
  input  logic [(1<<SEL_W)-1:0] mask,
  input  logic [SEL_W-1:0]      idx,
  input  logic                  incl,
  input  logic                  wrap,
  output logic [SEL_W-1:0]      nxt,
  output logic                  found
);

  localparam int N = 1 << SEL_W;

  // One extra bit so that idx = N-1 with incl = 0 gives an all-ones
  // low mask, i.e. an empty candidate set.
  logic [N:0]   lowmask;
  logic [N-1:0] cand;

  always_comb begin
    lowmask = incl ? ((N+1)'(1) << idx) : ((N+1)'(2) << idx);
    lowmask = lowmask - (N+1)'(1);
    cand    = mask & ~lowmask[N-1:0];
    if (cand == '0 && wrap) begin
      cand = mask;
    end
    found = 1'b0;
    nxt   = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (cand[i-1]) begin
        found = 1'b1;
        nxt   = SEL_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 16:1 mux select through the enabled channels
// in ascending order, captures each selected word and offers it downstream
// on a valid/ready handshake tagged with its channel index.
// Configuration macro: SCAN_CONTINUOUS_EN -- when defined, the scan wraps
// from the highest enabled channel back to the lowest and never pulses done.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, starts a scan when idle
//   abort               ends a scan in progress without done
//   en_mask             channel enables, latched on accepted start
//   mux_out             data from the mux for the current sel
//   sel                 mux select
//   samp_valid/ready    sample handshake
//   samp_ch, samp_data  captured channel index and data
//   busy                high whenever not idle
//   done                one-cycle pulse at normal end of scan
module mux_scan_sequencer #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [(1<<SEL_W)-1:0] en_mask,
  input  logic [DATA_W-1:0]     mux_out,
  output logic [SEL_W-1:0]      sel,
  output logic                  samp_valid,
  input  logic                  samp_ready,
  output logic [SEL_W-1:0]      samp_ch,
  output logic [DATA_W-1:0]     samp_data,
  output logic                  busy,
  output logic                  done
);

  import scan_pkg::*;

  localparam int NCHAN = 1 << SEL_W;

`ifdef SCAN_CONTINUOUS_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  state_t           state;
  logic [NCHAN-1:0] mask_q;

  logic [SEL_W-1:0] first_ch;
  logic             first_found;
  logic [SEL_W-1:0] next_ch;
  logic             next_found;

  // Start search runs on the live en_mask, since the mask is latched on the
  // same edge that loads the first channel.
  next_chan_find #(.SEL_W(SEL_W)) u_find_first (
    .mask  (en_mask),
    .idx   ('0),
    .incl  (1'b1),
    .wrap  (1'b0),
    .nxt   (first_ch),
    .found (first_found)
  );

  next_chan_find #(.SEL_W(SEL_W)) u_find_next (
    .mask  (mask_q),
    .idx   (sel),
    .incl  (1'b0),
    .wrap  (WRAP),
    .nxt   (next_ch),
    .found (next_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mask_q     <= '0;
      sel        <= '0;
      samp_valid <= 1'b0;
      samp_ch    <= '0;
      samp_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask_q <= en_mask;
            busy   <= 1'b1;
            if (first_found) begin
              sel   <= first_ch;
              state <= ST_SEL;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_SEL: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            samp_data  <= mux_out;
            samp_ch    <= sel;
            samp_valid <= 1'b1;
            state      <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (abort) begin
            samp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (samp_ready) begin
            samp_valid <= 1'b0;
            if (next_found) begin
              sel   <= next_ch;
              state <= ST_SEL;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] en_mask = '0;
  logic [3:0]  mux_out;
  logic [3:0]  sel;
  logic        samp_valid;
  logic        samp_ready = 1'b0;
  logic [3:0]  samp_ch;
  logic [3:0]  samp_data;
  logic        busy;
  logic        done;

  logic [3:0] chans [16];
  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural 16:1 mux driven by the sequencer's select.
  assign mux_out = chans[sel];

  mux_scan_sequencer #(.DATA_W(4), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .en_mask    (en_mask),
    .mux_out    (mux_out),
    .sel        (sel),
    .samp_valid (samp_valid),
    .samp_ready (samp_ready),
    .samp_ch    (samp_ch),
    .samp_data  (samp_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic load_plan_data();
    logic [3:0] d [16] = '{4'b1010, 4'b1110, 4'b0010, 4'b0110, 4'b1011, 4'b1100,
                           4'b0111, 4'b1110, 4'b0101, 4'b0000, 4'b1001, 4'b1111,
                           4'b1011, 4'b1011, 4'b1110, 4'b0111};
    for (int i = 0; i < 16; i++) chans[i] = d[i];
  endtask

  task automatic outputs_zero(input string nm);
    tests++;
    if ({sel, samp_valid, samp_ch, samp_data, busy, done} !== 15'b0) begin
      errors++;
      $display("FAIL %s: sel=%0d valid=%0b ch=%0d data=%b busy=%0b done=%0b, required all 0",
               nm, sel, samp_valid, samp_ch, samp_data, busy, done);
    end
  endtask

  // Single-pass scan against a reference list built from the mask: ascending
  // enabled channels, data taken from the channel table. With ready held high
  // sample i hands over at edge 2i+1 and done appears after edge 2n.
  task automatic run_scan(input logic [15:0] m, input bit rnd_ready, input string nm);
    int exp_ch[$];
    int got = 0;
    int done_k = -1;
    bit stalled = 0;
    logic [3:0] held_ch, held_d;
    for (int i = 0; i < 16; i++) if (m[i]) exp_ch.push_back(i);
    samp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    en_mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    en_mask = 16'($urandom);  // must not affect a scan already running
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (stalled) begin
        tests++;
        if (!samp_valid || samp_ch !== held_ch || samp_data !== held_d) begin
          errors++;
          $display("FAIL %s stable: valid=%0b ch=%0d data=%b, required 1 ch=%0d data=%b",
                   nm, samp_valid, samp_ch, samp_data, held_ch, held_d);
        end
      end
      if (done) begin done_k = k; break; end
      stalled = samp_valid && !samp_ready;
      held_ch = samp_ch;
      held_d  = samp_data;
      if (samp_valid && samp_ready) begin
        tests++;
        if (exp_ch.size() == 0) begin
          errors++;
          $display("FAIL %s extra sample: ch=%0d, required none", nm, samp_ch);
        end else begin
          if (samp_ch !== 4'(exp_ch[0]) || samp_data !== chans[exp_ch[0]]) begin
            errors++;
            $display("FAIL %s sample: ch=%0d data=%b, required ch=%0d data=%b",
                     nm, samp_ch, samp_data, exp_ch[0], chans[exp_ch[0]]);
          end
          if (!rnd_ready && k != 2 * got + 1) begin
            errors++;
            $display("FAIL %s sample timing: edge %0d, required %0d", nm, k, 2 * got + 1);
          end
          void'(exp_ch.pop_front());
          got++;
        end
      end
      @(posedge clk); #1;
      if (rnd_ready) samp_ready = 1'($urandom_range(0, 1));
    end
    tests++;
    if (done_k < 0 || exp_ch.size() != 0) begin
      errors++;
      $display("FAIL %s completion: done_edge=%0d missing=%0d, required done with 0 missing",
               nm, done_k, exp_ch.size());
    end else if (!rnd_ready && done_k != 2 * got) begin
      errors++;
      $display("FAIL %s done timing: edge %0d, required %0d", nm, done_k, 2 * got);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: done=%0b busy=%0b, required 0 0", nm, done, busy);
    end
    samp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_scan();
    load_plan_data();
    run_scan(16'hFFFF, 1'b0, "full");
  endtask

  task automatic test_sparse();
    load_plan_data();
    run_scan(16'h8421, 1'b0, "sparse");
  endtask

  task automatic test_empty();
    en_mask = 16'h0000;
    samp_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || samp_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty first: done=%0b busy=%0b valid=%0b, required 1 1 0", done, busy, samp_valid);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || samp_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty second: done=%0b busy=%0b valid=%0b, required 0 0 0", done, busy, samp_valid);
    end
    samp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    load_plan_data();
    samp_ready = 1'b0;
    en_mask = 16'h0002;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (samp_valid !== 1'b1 || samp_ch !== 4'd1 || samp_data !== 4'b1110 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle %0d: valid=%0b ch=%0d data=%b done=%0b, required 1 1 1110 0",
                 c, samp_valid, samp_ch, samp_data, done);
      end
      @(posedge clk); #1;
    end
    samp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || samp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall release: done=%0b valid=%0b, required 1 0", done, samp_valid);
    end
    @(posedge clk); #1;
    samp_ready = 1'b0;
  endtask

  task automatic test_abort();
    bit hit = 0;
    load_plan_data();
    samp_ready = 1'b1;
    en_mask = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (samp_valid && samp_ch == 4'd3) hit = 1;
      else begin @(posedge clk); #1; end
    end
    tests++;
    if (!hit) begin
      errors++;
      $display("FAIL abort reach ch3: not seen, required within 40 cycles");
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || samp_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort idle cycle %0d: busy=%0b valid=%0b done=%0b, required 0 0 0",
                 c, busy, samp_valid, done);
      end
    end
    @(posedge clk); #1;
    run_scan(16'hFFFF, 1'b1, "restart");
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    load_plan_data();
    samp_ready = 1'b1;
    en_mask = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (samp_valid && samp_ch == 4'd7) hit = 1;
    end
    tests++;
    if (!hit) begin
      errors++;
      $display("FAIL reset reach ch7: not seen, required within 40 cycles");
    end
    rst = 1'b1;
    #1;
    outputs_zero("async reset");
    @(negedge clk);
    rst = 1'b0;
    samp_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) chans[i] = 4'($urandom);
      run_scan(16'($urandom), r[0], "random");
    end
  endtask

  task automatic test_continuous();
    int exp = 0;
    int got = 0;
    load_plan_data();
    samp_ready = 1'b1;
    en_mask = 16'h0003;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 60 && got < 8; k++) begin
      @(negedge clk);
      if (done) begin
        tests++;
        errors++;
        $display("FAIL continuous done: done=1, required 0");
      end
      if (samp_valid) begin
        tests++;
        if (samp_ch !== 4'(exp) || samp_data !== chans[exp]) begin
          errors++;
          $display("FAIL continuous sample: ch=%0d data=%b, required ch=%0d data=%b",
                   samp_ch, samp_data, exp, chans[exp]);
        end
        exp = 1 - exp;
        got++;
      end
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    tests++;
    if (got != 8 || busy !== 1'b0) begin
      errors++;
      $display("FAIL continuous end: samples=%0d busy=%0b, required 8 0", got, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) chans[i] = '0;
    test_reset();
`ifdef SCAN_CONTINUOUS_EN
    test_continuous();
`else
    test_full_scan();
    test_sparse();
    test_backpressure();
    test_empty();
    test_abort();
    test_async_reset();
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
